// File: rtl/sq_pkg.sv
// Shared types and constants for the rotating-square sequencer.
package sq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sq_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_UPPER = 7'b0011100;
    localparam logic [6:0] SEG_LOWER = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    function automatic logic [2:0] pos_step(input logic [2:0] pos, input logic up);
        return up ? pos + 3'd1 : pos - 3'd1;
    endfunction

    // Upper square walks digits 0..3, lower square walks back 3..0.
    function automatic logic [3:0] an_for_pos(input logic [2:0] pos);
        logic [1:0] digit;
        digit = pos[2] ? ~pos[1:0] : pos[1:0];
        return ~(4'b0001 << digit);
    endfunction

endpackage

// File: rtl/square_sequencer_if.sv
// Control and display signals of the square sequencer.
interface square_sequencer_if;
    logic       start;
    logic       stop;
    logic       step;
    logic       up;
    logic [1:0] speed;
    logic [3:0] laps;
    logic [3:0] an;
    logic [6:0] sseg;
    logic       running;
    logic       done;

    modport master (
        output start, stop, step, up, speed, laps,
        input  an, sseg, running, done
    );

    modport slave (
        input  start, stop, step, up, speed, laps,
        output an, sseg, running, done
    );
endinterface

// File: rtl/sq_tick_gen.sv
// Step-rate divider: tick every 2^(TICK_W-3+speed) enabled clocks, plus blink phase bit.
module sq_tick_gen #(
    parameter int unsigned TICK_W = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       tick,
    output logic       half
);

    localparam int TickWI = int'(TICK_W);

    logic [TICK_W-1:0] r_div;
    logic [TICK_W-1:0] w_mask;
    logic [TICK_W-1:0] w_top;

    // Mask covers divider bits [TICK_W-4+speed:0].
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < TickWI; i++) begin
            if (i <= TickWI - 4 + int'(speed)) begin
                w_mask[i] = 1'b1;
            end
        end
    end

    assign w_top = w_mask ^ (w_mask >> 1);
    assign tick  = en && ((r_div & w_mask) == w_mask);
    assign half  = |(r_div & w_top);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (clr) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/square_sequencer.sv
// Run/pause/step sequencer for the rotating-square display animation.
// Optional SQ_BLINK_EN: display blinks at the step rate while paused.
module square_sequencer
    import sq_pkg::*;
#(
    parameter int unsigned TICK_W = 26
) (
    input  logic              clk,
    input  logic              rst,
    square_sequencer_if.slave bus
);

`ifdef SQ_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    sq_state_t  r_state, w_state_next;
    logic [2:0] r_pos, w_pos_next;
    logic [3:0] r_lap, w_lap_next;
    logic [3:0] r_laps, w_laps_next;
    logic       r_done, w_done_next;

    logic       w_clr;
    logic       w_en;
    logic       w_tick;
    logic       w_half;
    logic [2:0] w_adv;
    logic       w_wrap;
    logic [3:0] w_lap_inc;
    logic       w_blank;

    sq_tick_gen #(
        .TICK_W(TICK_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .speed(bus.speed),
        .tick (w_tick),
        .half (w_half)
    );

    assign w_en      = (r_state == RUN) || (BLINK_EN && (r_state == PAUSE));
    assign w_adv     = pos_step(r_pos, bus.up);
    assign w_wrap    = bus.up ? (r_pos == 3'd7) : (r_pos == 3'd0);
    assign w_lap_inc = r_lap + 4'd1;

    always_comb begin
        w_state_next = r_state;
        w_pos_next   = r_pos;
        w_lap_next   = r_lap;
        w_laps_next  = r_laps;
        w_done_next  = 1'b0;
        w_clr        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    w_state_next = RUN;
                    w_clr        = 1'b1;
                    w_lap_next   = 4'd0;
                    w_laps_next  = bus.laps;
                end
            end
            RUN: begin
                // A stop on a tick cycle pauses without advancing.
                if (bus.stop) begin
                    w_state_next = PAUSE;
                    w_clr        = BLINK_EN;
                end else if (w_tick) begin
                    w_pos_next = w_adv;
                    if (w_wrap) begin
                        if ((r_laps != 4'd0) && (w_lap_inc == r_laps)) begin
                            w_state_next = PAUSE;
                            w_done_next  = 1'b1;
                            w_lap_next   = 4'd0;
                            w_clr        = BLINK_EN;
                        end else begin
                            w_lap_next = w_lap_inc;
                        end
                    end
                end
            end
            PAUSE: begin
                if (bus.start && !bus.stop) begin
                    w_state_next = RUN;
                    w_clr        = 1'b1;
                    w_lap_next   = 4'd0;
                    w_laps_next  = bus.laps;
                end else if (bus.step && !bus.start) begin
                    w_pos_next = w_adv;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pos   <= 3'd0;
            r_lap   <= 4'd0;
            r_laps  <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pos   <= w_pos_next;
            r_lap   <= w_lap_next;
            r_laps  <= w_laps_next;
            r_done  <= w_done_next;
        end
    end

    assign w_blank = (r_state == IDLE) || (BLINK_EN && (r_state == PAUSE) && w_half);

    always_comb begin
        bus.an   = AN_OFF;
        bus.sseg = SEG_BLANK;
        if (!w_blank) begin
            bus.an   = an_for_pos(r_pos);
            bus.sseg = r_pos[2] ? SEG_LOWER : SEG_UPPER;
        end
    end

    assign bus.running = (r_state == RUN);
    assign bus.done    = r_done;

endmodule

// File: tb/tb_square_sequencer.sv
// Self-checking bench for square_sequencer (TICK_W=4) against a behavioural model.
module tb_square_sequencer;

`ifdef SQ_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic clk;
    logic rst;
    square_sequencer_if sq_if ();

    square_sequencer #(
        .TICK_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 run, 2 pause; m_div counts clocks since last clear (mod 16).
    int m_mode, m_pos, m_div, m_lap, m_laps;
    bit m_done;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int period_now();
        return 1 << (int'(sq_if.speed) + 1);
    endfunction

    function automatic bit tick_pending();
        return (m_mode == 1) && ((m_div % period_now()) == period_now() - 1);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_div = 0; m_lap = 0; m_laps = 0; m_done = 0;
    endtask

    task automatic model_move();
        m_pos = sq_if.up ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
    endtask

    task automatic model_step();
        bit tick, to_run, to_pause;
        int old_mode;
        tick     = tick_pending();
        old_mode = m_mode;
        to_run   = 0;
        to_pause = 0;
        m_done   = 0;
        case (m_mode)
            0: if (sq_if.start && !sq_if.stop) to_run = 1;
            1: begin
                if (sq_if.stop) begin
                    to_pause = 1;
                end else if (tick) begin
                    model_move();
                    if ((sq_if.up && m_pos == 0) || (!sq_if.up && m_pos == 7)) begin
                        m_lap++;
                        if (m_laps != 0 && m_lap == m_laps) begin
                            to_pause = 1;
                            m_done   = 1;
                            m_lap    = 0;
                        end
                    end
                end
            end
            default: begin
                if (sq_if.start && !sq_if.stop) to_run = 1;
                else if (sq_if.step && !sq_if.start) model_move();
            end
        endcase
        if (to_run) begin
            m_mode = 1; m_lap = 0; m_laps = int'(sq_if.laps); m_div = 0;
        end else if (to_pause) begin
            m_mode = 2;
            if (BLINK) m_div = 0;
            else m_div = (m_div + 1) % 16;
        end else if (old_mode == 1 || (BLINK && old_mode == 2)) begin
            m_div = (m_div + 1) % 16;
        end
    endtask

    function automatic bit exp_blank();
        return (m_mode == 0) ||
               (BLINK && m_mode == 2 && (m_div % period_now()) >= period_now() / 2);
    endfunction

    function automatic logic [3:0] exp_an();
        int digit;
        if (exp_blank()) return 4'b1111;
        digit = (m_pos < 4) ? m_pos : 7 - m_pos;
        return 4'b1111 & ~(4'b0001 << digit);
    endfunction

    function automatic logic [6:0] exp_sseg();
        if (exp_blank()) return 7'b1111111;
        return (m_pos < 4) ? 7'b0011100 : 7'b0100011;
    endfunction

    task automatic compare();
        check_eq("an", 32'(sq_if.an), 32'(exp_an()));
        check_eq("sseg", 32'(sq_if.sseg), 32'(exp_sseg()));
        check_eq("running", 32'(sq_if.running), 32'(m_mode == 1));
        check_eq("done", 32'(sq_if.done), 32'(m_done));
    endtask

    // Inputs held through the edge; outputs checked 1 time unit after it.
    task automatic run_cycle(input logic s_start, input logic s_stop, input logic s_step);
        sq_if.start = s_start;
        sq_if.stop  = s_stop;
        sq_if.step  = s_step;
        @(posedge clk);
        model_step();
        #1;
        compare();
        sq_if.start = 1'b0;
        sq_if.stop  = 1'b0;
        sq_if.step  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare();
    endtask

    initial begin
        int done_cnt;
        bit found;
        rst         = 1'b1;
        sq_if.start = 1'b0;
        sq_if.stop  = 1'b0;
        sq_if.step  = 1'b0;
        sq_if.up    = 1'b1;
        sq_if.speed = 2'd0;
        sq_if.laps  = 4'd0;
        model_reset();
        #2;
        check_eq("reset_an", 32'(sq_if.an), 32'h0000000f);
        check_eq("reset_sseg", 32'(sq_if.sseg), 32'h0000007f);
        check_eq("reset_running", 32'(sq_if.running), 32'd0);
        check_eq("reset_done", 32'(sq_if.done), 32'd0);
        do_reset();

        // Free run, speed 0, clockwise, no lap limit.
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("run_first_an", 32'(sq_if.an), 32'he);
        check_eq("run_first_sseg", 32'(sq_if.sseg), 32'h1c);
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_an", 32'(sq_if.an), 32'hf);
        check_eq("async_rst_sseg", 32'(sq_if.sseg), 32'h7f);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare();

        // Two laps at speed 3: 16 advances, one done pulse.
        sq_if.laps  = 4'd2;
        sq_if.speed = 2'd3;
        run_cycle(1'b1, 1'b0, 1'b0);
        check_eq("laps_start_an", 32'(sq_if.an), 32'he);
        done_cnt = 0;
        for (int i = 0; i < 270; i++) begin
            run_cycle(1'b0, 1'b0, 1'b0);
            if (sq_if.done) done_cnt++;
        end
        check_eq("laps_done_count", 32'(done_cnt), 32'd1);
        check_eq("laps_end_running", 32'(sq_if.running), 32'd0);
        check_eq("laps_end_an", 32'(sq_if.an), 32'he);

        // Stop on a tick cycle at pos 2, then step counter-clockwise.
        sq_if.laps  = 4'd0;
        sq_if.speed = 2'd0;
        run_cycle(1'b1, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_pos == 2 && tick_pending()) found = 1;
            else run_cycle(1'b0, 1'b0, 1'b0);
        end
        check_eq("stop_tick_found", 32'(found), 32'd1);
        run_cycle(1'b0, 1'b1, 1'b0);
        check_eq("stop_tick_an", 32'(sq_if.an), 32'hb);
        check_eq("stop_tick_running", 32'(sq_if.running), 32'd0);
        sq_if.speed = 2'd3;
        sq_if.up    = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b1);
        check_eq("step_pos7_an", 32'(sq_if.an), 32'he);
        check_eq("step_pos7_sseg", 32'(sq_if.sseg), 32'h23);

        // start+stop in PAUSE stays paused.
        run_cycle(1'b1, 1'b1, 1'b0);
        check_eq("pause_startstop_running", 32'(sq_if.running), 32'd0);

        // Blink (or steady) display in PAUSE at speed 0.
        sq_if.speed = 2'd0;
        for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 1'b0);

        // Resume: lap counter is cleared on re-entry; a lap-1 run ends on first wrap.
        sq_if.up   = 1'b1;
        sq_if.laps = 4'd1;
        run_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) run_cycle(1'b0, 1'b0, 1'b0);

        // step in IDLE stays blank.
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b1);
        check_eq("idle_step_an", 32'(sq_if.an), 32'hf);
        run_cycle(1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) sq_if.speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) sq_if.up = 1'($urandom_range(0, 1));
            sq_if.laps = 4'($urandom_range(0, 3));
            run_cycle(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 59) == 0),
                      1'($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
